// File: rtl/latch_ctrl_pkg.sv
// Shared types for the latch-bank write arbiter.
// Holds the controller state encoding and sizing helpers.
package latch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int CNT_W = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Search starts one past the last winner and wraps.
module rr_pick
  import latch_ctrl_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int PW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic            valid
);

  int            sum;
  logic [PW-1:0] idx;

  // first requester at or after ptr+1, modulo NREQ
  always_comb begin
    grant = '0;
    valid = 1'b0;
    sum   = 0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      sum = (int'(ptr) + i) % NREQ;
      idx = PW'(sum);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/latch_wr_arbiter.sv
// Round-robin write arbiter for a latch bank.
// Sequences setup, gate-open and hold phases per write.
module latch_wr_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter  int DW       = 8,
  parameter  int NW       = 8,
  parameter  int NREQ     = 4,
  parameter  int OPEN_CYC = 2,
  localparam int AW       = idx_w(NW),
  localparam int PW       = idx_w(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  output logic               busy,
  output logic [DW-1:0]      lat_d,
  output logic [NW-1:0]      lat_en_n
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  win_q, win_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    lat_d_q, lat_d_d;
  logic [NW-1:0]    lat_en_n_q, lat_en_n_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             busy_q, busy_d;

  logic [NREQ-1:0]  pick_grant;
  logic             pick_valid;
  logic [PW-1:0]    gidx;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // winner index plus its address and data slices
  always_comb begin
    gidx     = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) begin
        gidx     = PW'(i);
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // next state and next registered outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    addr_d     = addr_q;
    lat_d_d    = lat_d_q;
    lat_en_n_d = '1;
    ack_d      = '0;
    busy_d     = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (pick_valid) begin
          state_d = SETUP;
          ptr_d   = gidx;
          win_d   = pick_grant;
          addr_d  = sel_addr;
          lat_d_d = sel_data;
          busy_d  = 1'b1;
        end
      end
      SETUP: begin
        state_d    = OPEN;
        cnt_d      = '0;
        lat_en_n_d = ~(NW'(1) << addr_q);
      end
      OPEN: begin
        if (cnt_q == CNT_W'(OPEN_CYC - 1)) begin
          state_d = HOLD;
          ack_d   = win_q;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          lat_en_n_d = ~(NW'(1) << addr_q);
        end
      end
      HOLD: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // state and output registers; reset closes every gate at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= PW'(NREQ - 1);
      win_q      <= '0;
      addr_q     <= '0;
      lat_d_q    <= '0;
      lat_en_n_q <= '1;
      ack_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      addr_q     <= addr_d;
      lat_d_q    <= lat_d_d;
      lat_en_n_q <= lat_en_n_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign busy     = busy_q;
  assign lat_d    = lat_d_q;
  assign lat_en_n = lat_en_n_q;

endmodule

// File: tb/tb_latch_wr_arbiter.sv
// Self-checking bench for latch_wr_arbiter.
// Directed scenarios plus a random run against a timing model.
module tb_latch_wr_arbiter;

  localparam int DW   = 8;
  localparam int NW   = 8;
  localparam int NREQ = 4;
  localparam int OC   = 2;
  localparam int AW   = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    ack;
  logic               busy;
  logic [DW-1:0]      lat_d;
  logic [NW-1:0]      lat_en_n;

  int n_cmp = 0;
  int n_bad = 0;

  latch_wr_arbiter #(
    .DW(DW), .NW(NW), .NREQ(NREQ), .OPEN_CYC(OC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .ack      (ack),
    .busy     (busy),
    .lat_d    (lat_d),
    .lat_en_n (lat_en_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rq(input int i, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    n_cmp++;
    if (lat_en_n !== 8'hFF) begin
      n_bad++;
      $display("FAIL rst_en got=%h exp=ff", lat_en_n);
    end
    n_cmp++;
    if (ack !== 4'b0) begin
      n_bad++;
      $display("FAIL rst_ack got=%b exp=0000", ack);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_busy got=%b exp=0", busy);
    end
    n_cmp++;
    if (lat_d !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_latd got=%h exp=00", lat_d);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [DW-1:0] ge [1:5];
    logic [NW-1:0] gn [1:5];
    logic [3:0]    ga [1:5];
    logic          gb [1:5];
    set_rq(0, 3'd5, 8'hA5);
    req = 4'b0001;
    tick();
    req = '0;
    for (int c = 1; c <= 5; c++) begin
      ge[c] = lat_d;
      gn[c] = lat_en_n;
      ga[c] = ack;
      gb[c] = busy;
      if (c < 5) tick();
    end
    for (int c = 1; c <= 5; c++) begin
      logic [NW-1:0] xn;
      logic [3:0]    xa;
      xn = (c == 2 || c == 3) ? 8'hDF : 8'hFF;
      xa = (c == 4) ? 4'b0001 : 4'b0000;
      n_cmp++;
      if (gn[c] !== xn || ga[c] !== xa || ge[c] !== 8'hA5 ||
          gb[c] !== (c < 5)) begin
        n_bad++;
        $display("FAIL single k+%0d got en=%h ack=%b d=%h b=%b exp en=%h ack=%b d=a5 b=%b",
                 c, gn[c], ga[c], ge[c], gb[c], xn, xa, c < 5);
      end
    end
  endtask

  task automatic test_data_change();
    set_rq(0, 3'd5, 8'hA5);
    req = 4'b0001;
    tick();
    tick();
    req_data[7:0] = 8'h00;
    for (int c = 2; c <= 4; c++) begin
      n_cmp++;
      if (lat_d !== 8'hA5) begin
        n_bad++;
        $display("FAIL dchg_latd k+%0d got=%h exp=a5", c, lat_d);
      end
      if (c == 4) begin
        n_cmp++;
        if (ack !== 4'b0001) begin
          n_bad++;
          $display("FAIL dchg_ack got=%b exp=0001", ack);
        end
        req = '0;
      end else begin
        tick();
      end
    end
    tick();
  endtask

  task automatic test_all_req();
    int order [5] = '{0, 1, 2, 3, 0};
    int n = 0;
    int since = -1;
    int cyc = 0;
    do_reset();
    for (int i = 0; i < NREQ; i++)
      set_rq(i, AW'(i + 1), 8'(8'h10 + i));
    req = 4'b1111;
    while (n < 5 && cyc < 60) begin
      tick();
      cyc++;
      if (since >= 0) since++;
      if (since == 1) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_bad++;
          $display("FAIL all_gap got busy=%b exp=0", busy);
        end
      end
      if (since == 2) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++;
          $display("FAIL all_regrant got busy=%b exp=1", busy);
        end
      end
      if (ack !== '0) begin
        logic [3:0] xa;
        xa = 4'b0001 << order[n];
        n_cmp++;
        if (ack !== xa || lat_d !== 8'(8'h10 + order[n])) begin
          n_bad++;
          $display("FAIL all_order #%0d got ack=%b d=%h exp ack=%b d=%h",
                   n, ack, lat_d, xa, 8'(8'h10 + order[n]));
        end
        n++;
        since = 0;
        if (n == 5) req = '0;
      end
    end
    n_cmp++;
    if (n != 5) begin
      n_bad++;
      $display("FAIL all_timeout got acks=%0d exp=5", n);
    end
    tick();
  endtask

  task automatic test_reset_in_open();
    do_reset();
    set_rq(0, 3'd3, 8'h3C);
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    n_cmp++;
    if (lat_en_n !== 8'hF7) begin
      n_bad++;
      $display("FAIL rio_open got=%h exp=f7", lat_en_n);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (lat_en_n !== 8'hFF || ack !== 4'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rio_async got en=%h ack=%b b=%b exp en=ff ack=0000 b=0",
               lat_en_n, ack, busy);
    end
    tick();
    n_cmp++;
    if (lat_en_n !== 8'hFF || ack !== 4'b0) begin
      n_bad++;
      $display("FAIL rio_held got en=%h ack=%b exp en=ff ack=0000",
               lat_en_n, ack);
    end
    reset = 1'b0;
    set_rq(2, 3'd6, 8'h5A);
    req = 4'b0100;
    tick();
    req = '0;
    n_cmp++;
    if (busy !== 1'b1 || lat_d !== 8'h5A) begin
      n_bad++;
      $display("FAIL rio_first got b=%b d=%h exp b=1 d=5a", busy, lat_d);
    end
    tick();
    tick();
    n_cmp++;
    if (ack !== 4'b0) begin
      n_bad++;
      $display("FAIL rio_noack got=%b exp=0000", ack);
    end
    tick();
    n_cmp++;
    if (ack !== 4'b0100) begin
      n_bad++;
      $display("FAIL rio_ack got=%b exp=0100", ack);
    end
    tick();
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_mem [NW];
    logic [DW-1:0] lat_mem [NW];
    bit            active = 0;
    int            last = NREQ - 1;
    int            k = 0;
    int            w = 0;
    logic [AW-1:0] w_addr = '0;
    logic [DW-1:0] w_data = '0;
    logic [DW-1:0] last_data = '0;
    do_reset();
    for (int i = 0; i < NW; i++) begin
      exp_mem[i] = '0;
      lat_mem[i] = '0;
    end
    for (int e = 1; e <= 1000; e++) begin
      int            off;
      logic [NW-1:0] xe;
      logic [3:0]    xa;
      logic          xb;
      logic [DW-1:0] xd;
      bit            mem_ok;
      req      = ($urandom_range(0, 3) == 0) ? 4'(($urandom)) : 4'b0;
      req_addr = 12'($urandom);
      req_data = 32'($urandom);
      @(posedge clk);
      if (active) begin
        if (e == k + 2 + OC) active = 0;
      end else if (req != '0) begin
        for (int j = 1; j <= NREQ; j++) begin
          int c;
          c = (last + j) % NREQ;
          if (!active && req[c]) begin
            active = 1;
            w      = c;
          end
        end
        k         = e;
        w_addr    = req_addr[w*AW +: AW];
        w_data    = req_data[w*DW +: DW];
        last      = w;
        last_data = w_data;
      end
      #1;
      off = e + 1 - k;
      xe  = 8'hFF;
      xa  = 4'b0;
      xb  = active;
      xd  = last_data;
      if (active) begin
        if (off >= 2 && off <= 1 + OC) xe[w_addr] = 1'b0;
        if (off == 2 + OC) xa[w] = 1'b1;
      end
      n_cmp++;
      if (lat_en_n !== xe || ack !== xa || busy !== xb || lat_d !== xd) begin
        n_bad++;
        $display("FAIL rand_out cyc=%0d got en=%h ack=%b b=%b d=%h exp en=%h ack=%b b=%b d=%h",
                 e, lat_en_n, ack, busy, lat_d, xe, xa, xb, xd);
      end
      n_cmp++;
      if ($countones(~lat_en_n) > 1) begin
        n_bad++;
        $display("FAIL rand_overlap cyc=%0d got en=%h exp <=1 low", e, lat_en_n);
      end
      for (int i = 0; i < NW; i++)
        if (lat_en_n[i] === 1'b0) lat_mem[i] = lat_d;
      if (xa != '0) begin
        exp_mem[w_addr] = w_data;
        mem_ok = 1;
        for (int i = 0; i < NW; i++)
          if (lat_mem[i] !== exp_mem[i]) mem_ok = 0;
        n_cmp++;
        if (!mem_ok) begin
          n_bad++;
          $display("FAIL rand_latch cyc=%0d got w%0d=%h exp=%h",
                   e, w_addr, lat_mem[w_addr], w_data);
        end
      end
    end
    req = '0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_data_change();
    test_all_req();
    test_reset_in_open();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
